// File: rtl/math_peak_find_17.sv
// math_peak_find_17: frame-based peak search over an unsigned magnitude stream.
// Optional second-peak tracking is built when MATH_PEAK_SECOND_EN is defined.
//
// Ports:
//   clk        - single clock
//   rst        - asynchronous active-low reset
//   ena        - global clock enable; all registers hold when low
//   din        - unsigned magnitude sample (WIDTH bits)
//   din_vld    - sample qualifier
//   din_last   - last sample of the frame (with din_vld)
//   peak       - frame maximum value
//   peak_idx   - 0-based index of the maximum (earliest on ties)
//   frame_len  - accepted samples in the frame, saturating at 2^IDX_BITS
//   ovf        - frame held more than 2^IDX_BITS samples
//   peak_vld   - one-cycle result strobe
//   peak2      - second-highest sample (0 unless MATH_PEAK_SECOND_EN)
//   peak2_idx  - index of the second-highest sample
module math_peak_find_17 #(
    parameter int WIDTH    = 17,
    parameter int IDX_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [WIDTH-1:0]    din,
    input  logic                din_vld,
    input  logic                din_last,
    output logic [WIDTH-1:0]    peak,
    output logic [IDX_BITS-1:0] peak_idx,
    output logic [IDX_BITS:0]   frame_len,
    output logic                ovf,
    output logic                peak_vld,
    output logic [WIDTH-1:0]    peak2,
    output logic [IDX_BITS-1:0] peak2_idx
);

    localparam logic [IDX_BITS-1:0] IDX_MAX = {IDX_BITS{1'b1}};
    localparam logic [IDX_BITS:0]   CNT_ONE = {{IDX_BITS{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_BITS:0]   r_cnt;
    logic [WIDTH-1:0]    r_max;
    logic [IDX_BITS-1:0] r_max_idx;
    logic                r_ovf;

    logic [WIDTH-1:0]    r_peak;
    logic [IDX_BITS-1:0] r_peak_idx;
    logic [IDX_BITS:0]   r_frame_len;
    logic                r_res_ovf;
    logic                r_peak_vld;

    logic                w_acc;
    logic                w_scan;
    logic [IDX_BITS:0]   w_cnt;
    logic [WIDTH-1:0]    w_max;
    logic [IDX_BITS-1:0] w_max_idx;
    logic                w_ovf;
    logic                w_sat;
    logic [IDX_BITS-1:0] w_cur_idx;
    logic [IDX_BITS:0]   w_cnt_nxt;
    logic                w_ovf_nxt;
    logic                w_gt;
    logic [WIDTH-1:0]    w_max_nxt;
    logic [IDX_BITS-1:0] w_max_idx_nxt;

    assign w_acc  = ena & din_vld;
    assign w_scan = (r_state == S_SCAN);

    // In IDLE the running values are taken as zero, so the first sample
    // of a frame goes through the same update rule as every other one.
    assign w_cnt     = w_scan ? r_cnt     : '0;
    assign w_max     = w_scan ? r_max     : '0;
    assign w_max_idx = w_scan ? r_max_idx : '0;
    assign w_ovf     = w_scan ? r_ovf     : 1'b0;

    // cnt reaching 2^IDX_BITS means this sample is beyond the frame limit.
    assign w_sat     = w_cnt[IDX_BITS];
    assign w_cur_idx = w_sat ? IDX_MAX : w_cnt[IDX_BITS-1:0];
    assign w_cnt_nxt = w_sat ? w_cnt : w_cnt + CNT_ONE;
    assign w_ovf_nxt = w_ovf | w_sat;

    assign w_gt          = din > w_max;
    assign w_max_nxt     = w_gt ? din : w_max;
    assign w_max_idx_nxt = w_gt ? w_cur_idx : w_max_idx;

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            if (din_last) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_SCAN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_max       <= '0;
            r_max_idx   <= '0;
            r_ovf       <= 1'b0;
            r_peak      <= '0;
            r_peak_idx  <= '0;
            r_frame_len <= '0;
            r_res_ovf   <= 1'b0;
            r_peak_vld  <= 1'b0;
        end else if (ena) begin
            r_peak_vld <= w_acc & din_last;
            if (w_acc) begin
                if (din_last) begin
                    r_cnt       <= '0;
                    r_max       <= '0;
                    r_max_idx   <= '0;
                    r_ovf       <= 1'b0;
                    r_peak      <= w_max_nxt;
                    r_peak_idx  <= w_max_idx_nxt;
                    r_frame_len <= w_cnt_nxt;
                    r_res_ovf   <= w_ovf_nxt;
                end else begin
                    r_cnt     <= w_cnt_nxt;
                    r_max     <= w_max_nxt;
                    r_max_idx <= w_max_idx_nxt;
                    r_ovf     <= w_ovf_nxt;
                end
            end
        end
    end

`ifdef MATH_PEAK_SECOND_EN
    logic [WIDTH-1:0]    r_sec;
    logic [IDX_BITS-1:0] r_sec_idx;
    logic [WIDTH-1:0]    r_peak2;
    logic [IDX_BITS-1:0] r_peak2_idx;
    logic [WIDTH-1:0]    w_sec;
    logic [IDX_BITS-1:0] w_sec_idx;
    logic                w_sec_gt;
    logic [WIDTH-1:0]    w_sec_nxt;
    logic [IDX_BITS-1:0] w_sec_idx_nxt;

    assign w_sec     = w_scan ? r_sec     : '0;
    assign w_sec_idx = w_scan ? r_sec_idx : '0;
    assign w_sec_gt  = din > w_sec;

    // A new max demotes the old max; otherwise din may replace second.
    assign w_sec_nxt = w_gt     ? w_max :
                       w_sec_gt ? din   : w_sec;
    assign w_sec_idx_nxt = w_gt     ? w_max_idx :
                           w_sec_gt ? w_cur_idx : w_sec_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec       <= '0;
            r_sec_idx   <= '0;
            r_peak2     <= '0;
            r_peak2_idx <= '0;
        end else if (ena && w_acc) begin
            if (din_last) begin
                r_sec       <= '0;
                r_sec_idx   <= '0;
                r_peak2     <= w_sec_nxt;
                r_peak2_idx <= w_sec_idx_nxt;
            end else begin
                r_sec     <= w_sec_nxt;
                r_sec_idx <= w_sec_idx_nxt;
            end
        end
    end

    assign peak2     = r_peak2;
    assign peak2_idx = r_peak2_idx;
`else
    assign peak2     = '0;
    assign peak2_idx = '0;
`endif

    assign peak      = r_peak;
    assign peak_idx  = r_peak_idx;
    assign frame_len = r_frame_len;
    assign ovf       = r_res_ovf;
    assign peak_vld  = r_peak_vld;

endmodule

// File: tb/tb_math_peak_find_17.sv
// tb_math_peak_find_17: directed, table-driven bench for math_peak_find_17.
// A second instance with IDX_BITS=3 covers count saturation and overflow.
module tb_math_peak_find_17;

`ifdef MATH_PEAK_SECOND_EN
    localparam bit SEC = 1'b1;
`else
    localparam bit SEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [16:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_last = 1'b0;
    logic [16:0] peak;
    logic [9:0]  peak_idx;
    logic [10:0] frame_len;
    logic        ovf;
    logic        peak_vld;
    logic [16:0] peak2;
    logic [9:0]  peak2_idx;

    logic        s_ena = 1'b0;
    logic [16:0] s_din = '0;
    logic        s_vld = 1'b0;
    logic        s_last = 1'b0;
    logic [16:0] s_peak;
    logic [2:0]  s_peak_idx;
    logic [3:0]  s_frame_len;
    logic        s_ovf;
    logic        s_peak_vld;
    logic [16:0] s_peak2;
    logic [2:0]  s_peak2_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    math_peak_find_17 #(.WIDTH(17), .IDX_BITS(10)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din),
        .din_vld(din_vld), .din_last(din_last),
        .peak(peak), .peak_idx(peak_idx), .frame_len(frame_len),
        .ovf(ovf), .peak_vld(peak_vld),
        .peak2(peak2), .peak2_idx(peak2_idx)
    );

    math_peak_find_17 #(.WIDTH(17), .IDX_BITS(3)) dut_s (
        .clk(clk), .rst(rst), .ena(s_ena), .din(s_din),
        .din_vld(s_vld), .din_last(s_last),
        .peak(s_peak), .peak_idx(s_peak_idx), .frame_len(s_frame_len),
        .ovf(s_ovf), .peak_vld(s_peak_vld),
        .peak2(s_peak2), .peak2_idx(s_peak2_idx)
    );

    typedef struct {
        logic        e;
        logic        v;
        logic        l;
        logic [16:0] d;
        logic        xv;
        logic        rc;
        logic [16:0] xp;
        logic [9:0]  xi;
        logic [10:0] xl;
        logic [16:0] xp2;
        logic [9:0]  xp2i;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic e, input logic v, input logic l,
                        input logic [16:0] d, input logic xv,
                        input logic rc, input logic [16:0] xp,
                        input logic [9:0] xi, input logic [10:0] xl,
                        input logic [16:0] xp2, input logic [9:0] xp2i);
        vec_t t;
        t.e = e; t.v = v; t.l = l; t.d = d; t.xv = xv; t.rc = rc;
        t.xp = xp; t.xi = xi; t.xl = xl; t.xp2 = xp2; t.xp2i = xp2i;
        tbl.push_back(t);
    endtask

    task automatic send(input logic e, input logic v, input logic l,
                        input logic [16:0] d);
        ena = e; din_vld = v; din_last = l; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_s(input logic v, input logic l,
                          input logic [16:0] d);
        s_ena = 1'b1; s_vld = v; s_last = l; s_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic frame 5,9,3,12,12,7,1,4
        addv(1,1,0,5, 0,1,0,0,0,0,0);
        addv(1,1,0,9, 0,0,0,0,0,0,0);
        addv(1,1,0,3, 0,0,0,0,0,0,0);
        addv(1,1,0,12,0,0,0,0,0,0,0);
        addv(1,1,0,12,0,0,0,0,0,0,0);
        addv(1,1,0,7, 0,0,0,0,0,0,0);
        addv(1,1,0,1, 0,0,0,0,0,0,0);
        addv(1,1,1,4, 1,1,12,3,8,12,4);
        addv(1,0,0,0, 0,1,12,3,8,12,4);
        // single-sample frame then back-to-back two-sample frame
        addv(1,1,1,17'h1FFFF,1,1,17'h1FFFF,0,1,0,0);
        addv(1,1,0,2, 0,1,17'h1FFFF,0,1,0,0);
        addv(1,1,1,6, 1,1,6,1,2,2,0);
        addv(1,0,0,0, 0,0,0,0,0,0,0);
        // basic frame again with ena and din_vld gaps
        addv(1,1,0,5, 0,0,0,0,0,0,0);
        addv(1,1,0,9, 0,0,0,0,0,0,0);
        addv(0,1,1,200,0,0,0,0,0,0,0);
        addv(0,1,1,200,0,0,0,0,0,0,0);
        addv(0,1,1,200,0,1,6,1,2,2,0);
        addv(1,1,0,3, 0,0,0,0,0,0,0);
        addv(1,0,1,99,0,0,0,0,0,0,0);
        addv(1,0,1,99,0,0,0,0,0,0,0);
        addv(1,1,0,12,0,0,0,0,0,0,0);
        addv(1,1,0,12,0,0,0,0,0,0,0);
        addv(1,1,0,7, 0,0,0,0,0,0,0);
        addv(1,1,0,1, 0,0,0,0,0,0,0);
        addv(1,1,1,4, 1,1,12,3,8,12,4);
        addv(0,1,1,77,1,1,12,3,8,12,4);
        addv(1,0,0,0, 0,1,12,3,8,12,4);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_peak", peak, 0);
        chk("rst_idx", peak_idx, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_vld", peak_vld, 0);
        chk("rst_peak2", peak2, 0);
        chk("rst_s_len", s_frame_len, 0);
        rst = 1'b1;
        send(1,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].e, tbl[i].v, tbl[i].l, tbl[i].d);
            chk($sformatf("v%0d_vld", i), peak_vld, tbl[i].xv);
            if (tbl[i].rc) begin
                chk($sformatf("v%0d_peak", i), peak, tbl[i].xp);
                chk($sformatf("v%0d_idx", i), peak_idx, tbl[i].xi);
                chk($sformatf("v%0d_len", i), frame_len, tbl[i].xl);
                chk($sformatf("v%0d_ovf", i), ovf, 0);
                chk($sformatf("v%0d_peak2", i), peak2,
                    SEC ? tbl[i].xp2 : 17'd0);
                chk($sformatf("v%0d_p2idx", i), peak2_idx,
                    SEC ? tbl[i].xp2i : 10'd0);
            end
        end

        // overflow on the IDX_BITS=3 instance: 1..9 then 100
        for (int k = 1; k <= 9; k++) begin
            send_s(1'b1, 1'b0, 17'(k));
            chk("ovf_mid_vld", s_peak_vld, 0);
        end
        send_s(1'b1, 1'b1, 17'd100);
        chk("ovf_vld", s_peak_vld, 1);
        chk("ovf_peak", s_peak, 100);
        chk("ovf_idx", s_peak_idx, 7);
        chk("ovf_len", s_frame_len, 8);
        chk("ovf_flag", s_ovf, 1);
        chk("ovf_peak2", s_peak2, SEC ? 17'd9 : 17'd0);
        chk("ovf_p2idx", s_peak2_idx, SEC ? 3'd7 : 3'd0);
        send_s(1'b1, 1'b0, 17'd4);
        chk("ovf_clr_vld", s_peak_vld, 0);
        send_s(1'b1, 1'b1, 17'd2);
        chk("nrm_vld", s_peak_vld, 1);
        chk("nrm_peak", s_peak, 4);
        chk("nrm_idx", s_peak_idx, 0);
        chk("nrm_len", s_frame_len, 2);
        chk("nrm_ovf", s_ovf, 0);
        chk("nrm_peak2", s_peak2, SEC ? 17'd2 : 17'd0);
        chk("nrm_p2idx", s_peak2_idx, SEC ? 3'd1 : 3'd0);
        send_s(1'b0, 1'b0, 17'd0);

        // reset mid-frame discards the partial frame holding 50
        send(1,1,0,7);
        send(1,1,0,50);
        send(1,1,0,3);
        send(1,1,0,1);
        ena = 1'b1; din_vld = 1'b0; din_last = 1'b0; din = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_peak", peak, 0);
        chk("arst_idx", peak_idx, 0);
        chk("arst_len", frame_len, 0);
        chk("arst_vld", peak_vld, 0);
        chk("arst_s_peak", s_peak, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_peak", peak, 0);
        rst = 1'b1;
        send(1,1,0,3);
        chk("post_mid_vld", peak_vld, 0);
        send(1,1,1,8);
        chk("post_vld", peak_vld, 1);
        chk("post_peak", peak, 8);
        chk("post_idx", peak_idx, 1);
        chk("post_len", frame_len, 2);
        chk("post_ovf", ovf, 0);
        chk("post_peak2", peak2, SEC ? 17'd3 : 17'd0);
        chk("post_p2idx", peak2_idx, 0);
        send(1,0,0,0);
        chk("post_idle_vld", peak_vld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
